// File: rtl/isolated_share_pkg.sv
// Shared types and constants for the isolated share remasker.
// Holds the FSM state encoding, the mode encoding and the legal parameter ranges.
package isolated_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROC  = 2'd1,
        ST_PRECH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic MODE_REFRESH = 1'b0;
    localparam logic MODE_UNMASK  = 1'b1;

    localparam int NSHARES_MIN = 2;
    localparam int NSHARES_MAX = 4;
    localparam int GAP_MIN     = 0;
    localparam int GAP_MAX     = 3;

    // Precharge counter width; covers GAP up to GAP_MAX.
    localparam int PCNT_W = 2;

    function automatic bit nshares_legal(input int n);
        return (n >= NSHARES_MIN) && (n <= NSHARES_MAX);
    endfunction

    function automatic bit gap_legal(input int g);
        return (g >= GAP_MIN) && (g <= GAP_MAX);
    endfunction

endpackage

// File: rtl/share_step_sequencer.sv
// Share index and precharge counters for the remasker FSM.
// Tells the FSM which share is current, whether it is the last one,
// and when the precharge gap has run out.
module share_step_sequencer
    import isolated_share_pkg::*;
#(
    parameter int NSHARES = 2,
    parameter int GAP     = 1,
    parameter int IDX_W   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_proc,
    input  logic             i_prech,
    output logic [IDX_W-1:0] o_idx,
    output logic [IDX_W-1:0] o_next_idx,
    output logic             o_last,
    output logic             o_prech_last
);

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NSHARES - 1);
    localparam logic [PCNT_W-1:0] PRECH_LAST = PCNT_W'((GAP > 0) ? GAP - 1 : 0);

    logic [IDX_W-1:0]  r_idx;
    logic [PCNT_W-1:0] r_pcnt;

    assign o_idx        = r_idx;
    assign o_next_idx   = r_idx + IDX_W'(1);
    assign o_last       = (r_idx == LAST_IDX);
    assign o_prech_last = (r_pcnt == PRECH_LAST);

    // Advance the index after a share step, directly or at the end of the precharge gap.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_pcnt <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
            r_pcnt <= '0;
        end else if (i_proc && !o_last && (GAP == 0)) begin
            r_idx <= o_next_idx;
        end else if (i_prech) begin
            if (o_prech_last) begin
                r_idx  <= o_next_idx;
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/isolated_share_remasker.sv
// Share remasker: refreshes a boolean-masked value with fresh randomness,
// or unmasks it, touching one share per cycle through a single datapath
// register that is precharged to zero between share steps.
module isolated_share_remasker
    import isolated_share_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NSHARES = 2,
    parameter int GAP     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NSHARES*WIDTH-1:0]   in_shares,
    input  logic                       mode,
    input  logic [WIDTH-1:0]           rnd,
    output logic                       rnd_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NSHARES*WIDTH-1:0]   out_shares,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NSHARES);

    if (!nshares_legal(NSHARES)) begin : g_bad_nshares
        $error("isolated_share_remasker: NSHARES out of range 2..4");
    end
    if (!gap_legal(GAP)) begin : g_bad_gap
        $error("isolated_share_remasker: GAP out of range 0..3");
    end

    state_e                         r_state;
    state_e                         w_next_state;
    logic                           r_mode;
    logic [NSHARES-1:0][WIDTH-1:0]  r_shares;
    logic [NSHARES-1:0][WIDTH-1:0]  r_out;
    logic [WIDTH-1:0]               r_dp;
    logic [WIDTH-1:0]               r_mask_acc;
    logic [WIDTH-1:0]               r_unmask_acc;
    logic [WIDTH-1:0]               w_dp;
    logic [WIDTH-1:0]               w_dp_next;
    logic                           w_accept;
    logic                           w_release;
    logic [IDX_W-1:0]               w_idx;
    logic [IDX_W-1:0]               w_next_idx;
    logic                           w_last;
    logic                           w_prech_last;

    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_release = out_ready && (r_state == ST_DONE);

    share_step_sequencer #(
        .NSHARES (NSHARES),
        .GAP     (GAP),
        .IDX_W   (IDX_W)
    ) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      ((r_state == ST_IDLE) || (r_state == ST_DONE)),
        .i_proc       (r_state == ST_PROC),
        .i_prech      (r_state == ST_PRECH),
        .o_idx        (w_idx),
        .o_next_idx   (w_next_idx),
        .o_last       (w_last),
        .o_prech_last (w_prech_last)
    );

    // Next state and handshake outputs.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        rnd_req      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next_state = ST_PROC;
            end
            ST_PROC: begin
                rnd_req = (r_mode == MODE_REFRESH) && !w_last;
                if (w_last)        w_next_state = ST_DONE;
                else if (GAP == 0) w_next_state = ST_PROC;
                else               w_next_state = ST_PRECH;
            end
            ST_PRECH: begin
                if (w_prech_last) w_next_state = ST_PROC;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign out_shares = out_valid ? r_out : '0;

    // One-share datapath: mask with rnd, close with the mask accumulator, or fold into the unmask sum.
    always_comb begin
        w_dp = r_dp ^ r_unmask_acc;
        if (r_mode == MODE_REFRESH) begin
            w_dp = w_last ? (r_dp ^ r_mask_acc) : (r_dp ^ rnd);
        end
    end

    // Datapath register load: the next share only on entry to PROC, zero otherwise (precharge).
    always_comb begin
        w_dp_next = '0;
        unique case (r_state)
            ST_IDLE:  if (in_valid)                 w_dp_next = in_shares[WIDTH-1:0];
            ST_PROC:  if (!w_last && (GAP == 0))    w_dp_next = r_shares[w_next_idx];
            ST_PRECH: if (w_prech_last)             w_dp_next = r_shares[w_next_idx];
            default:  w_dp_next = '0;
        endcase
    end

    // State, share storage, accumulators and result lanes.
    // NOTE: share storage is reset and zeroized explicitly; it holds secret material.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_REFRESH;
            r_shares     <= '0;
            r_out        <= '0;
            r_dp         <= '0;
            r_mask_acc   <= '0;
            r_unmask_acc <= '0;
        end else begin
            r_state <= w_next_state;
            r_dp    <= w_dp_next;
            if (w_accept) begin
                r_mode       <= mode;
                r_shares     <= in_shares;
                r_out        <= '0;
                r_mask_acc   <= '0;
                r_unmask_acc <= '0;
            end else if (r_state == ST_PROC) begin
                if (r_mode == MODE_REFRESH) begin
                    r_out[w_idx] <= w_dp;
                    if (!w_last) r_mask_acc <= r_mask_acc ^ rnd;
                end else begin
                    r_unmask_acc <= w_dp;
                    if (w_last) r_out[0] <= w_dp;
                end
            end else if (w_release) begin
                r_mode       <= MODE_REFRESH;
                r_shares     <= '0;
                r_out        <= '0;
                r_mask_acc   <= '0;
                r_unmask_acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_isolated_share_remasker.sv
// Directed bench for isolated_share_remasker: three instances cover
// NSHARES=2/GAP=1, NSHARES=3/GAP=0 and NSHARES=4/GAP=2.
module tb_isolated_share_remasker;
    import isolated_share_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  iv, md_a, or_a;
    logic [2:0]  ir, rr, ov, bz;
    logic [7:0]  rnd_a [3];
    logic [31:0] ish [3];
    logic [31:0] os [3];
    logic [15:0] os2;
    logic [23:0] os3;
    logic [31:0] os4;
    int          total;
    int          bad;

    assign os[0] = {16'h0, os2};
    assign os[1] = {8'h0, os3};
    assign os[2] = os4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    isolated_share_remasker #(.WIDTH(8), .NSHARES(2), .GAP(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_shares(ish[0][15:0]), .mode(md_a[0]), .rnd(rnd_a[0]), .rnd_req(rr[0]),
        .out_valid(ov[0]), .out_ready(or_a[0]), .out_shares(os2), .busy(bz[0])
    );

    isolated_share_remasker #(.WIDTH(8), .NSHARES(3), .GAP(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_shares(ish[1][23:0]), .mode(md_a[1]), .rnd(rnd_a[1]), .rnd_req(rr[1]),
        .out_valid(ov[1]), .out_ready(or_a[1]), .out_shares(os3), .busy(bz[1])
    );

    isolated_share_remasker #(.WIDTH(8), .NSHARES(4), .GAP(2)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_shares(ish[2]), .mode(md_a[2]), .rnd(rnd_a[2]), .rnd_req(rr[2]),
        .out_valid(ov[2]), .out_ready(or_a[2]), .out_shares(os4), .busy(bz[2])
    );

    task automatic check_idle_outputs(input string name);
        total++;
        if (ir !== 3'b111) begin bad++; $display("FAIL %s in_ready: got %b want 111", name, ir); end
        total++;
        if (ov !== 3'b000) begin bad++; $display("FAIL %s out_valid: got %b want 000", name, ov); end
        total++;
        if (rr !== 3'b000) begin bad++; $display("FAIL %s rnd_req: got %b want 000", name, rr); end
        total++;
        if (bz !== 3'b000) begin bad++; $display("FAIL %s busy: got %b want 000", name, bz); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (os[k] !== 32'h0) begin
                bad++; $display("FAIL %s out_shares[%0d]: got %h want 0", name, k, os[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    // One complete transaction on instance k, with latency, rnd_req and precharge tracking.
    task automatic run_op(input int k, input string name, input logic md,
                          input logic [31:0] shares, input logic [23:0] rnds,
                          input logic [31:0] exp_out, input int exp_lat,
                          input int exp_req, input int exp_prech, input int hold);
        int edges;
        int nreq;
        int nprech;
        edges = 0; nreq = 0; nprech = 0;
        @(negedge clk);
        iv[k] = 1'b1; md_a[k] = md; ish[k] = shares; rnd_a[k] = 8'hEE;
        total++;
        if (ir[k] !== 1'b1) begin bad++; $display("FAIL %s in_ready_pre: got %b want 1", name, ir[k]); end
        @(posedge clk);
        #1;
        iv[k] = 1'b0; md_a[k] = ~md; ish[k] = 32'hDEADBEEF;
        while (edges < 40) begin
            @(negedge clk);
            if (ov[k]) break;
            if (rr[k] && nreq < 3) begin
                rnd_a[k] = rnds[nreq*8 +: 8];
                nreq++;
            end else if (rr[k]) begin
                nreq++;
            end else begin
                rnd_a[k] = 8'hEE ^ 8'(edges);
            end
            if (k == 2 && u_d4.r_state == ST_PRECH) begin
                nprech++;
                total++;
                if (u_d4.r_dp !== 8'h00) begin
                    bad++; $display("FAIL %s prech_dp: got %h want 00", name, u_d4.r_dp);
                end
            end
            @(posedge clk);
            edges++;
        end
        total++;
        if (edges != exp_lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, edges, exp_lat); end
        total++;
        if (nreq != exp_req) begin bad++; $display("FAIL %s rnd_req_count: got %0d want %0d", name, nreq, exp_req); end
        if (k == 2) begin
            total++;
            if (nprech != exp_prech) begin
                bad++; $display("FAIL %s prech_cycles: got %0d want %0d", name, nprech, exp_prech);
            end
        end
        total++;
        if (os[k] !== exp_out) begin bad++; $display("FAIL %s out_shares: got %h want %h", name, os[k], exp_out); end
        total++;
        if (bz[k] !== 1'b1) begin bad++; $display("FAIL %s busy_done: got %b want 1", name, bz[k]); end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (os[k] !== exp_out || ov[k] !== 1'b1 || ir[k] !== 1'b0) begin
                bad++;
                $display("FAIL %s hold%0d: got out=%h ov=%b ir=%b want out=%h ov=1 ir=0",
                         name, h, os[k], ov[k], ir[k], exp_out);
            end
        end
        or_a[k] = 1'b1;
        @(posedge clk);
        #1;
        or_a[k] = 1'b0;
        @(negedge clk);
        total++;
        if (ov[k] !== 1'b0 || os[k] !== 32'h0 || ir[k] !== 1'b1 || bz[k] !== 1'b0) begin
            bad++;
            $display("FAIL %s release: got ov=%b out=%h ir=%b busy=%b want 0/0/1/0",
                     name, ov[k], os[k], ir[k], bz[k]);
        end
    endtask

    task automatic test_refresh_n2_hold();
        run_op(0, "n2_refresh", MODE_REFRESH, 32'h00003CA5, 24'h00000F, 32'h000033AA, 3, 1, 0, 5);
    endtask

    task automatic test_unmask_n2();
        run_op(0, "n2_unmask", MODE_UNMASK, 32'h00003CA5, 24'h0, 32'h00000099, 3, 0, 0, 0);
    endtask

    task automatic test_refresh_n3_gap0();
        run_op(1, "n3_refresh", MODE_REFRESH, 32'h00442211, 24'h000201, 32'h00472010, 3, 2, 0, 1);
    endtask

    task automatic test_unmask_n4_gap2();
        run_op(2, "n4_unmask", MODE_UNMASK, 32'h08040201, 24'h0, 32'h0000000F, 10, 0, 6, 0);
    endtask

    task automatic test_reset_in_prech();
        @(negedge clk);
        iv[2] = 1'b1; md_a[2] = MODE_REFRESH; ish[2] = 32'h08040201; rnd_a[2] = 8'h10;
        @(posedge clk);
        #1;
        iv[2] = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (u_d4.r_state !== ST_PRECH) begin
            bad++; $display("FAIL rst_prech_state: got %0d want %0d", u_d4.r_state, ST_PRECH);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_prech_during");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_prech_after");
        run_op(2, "n4_refresh_after_reset", MODE_REFRESH, 32'h08040201, 24'h402010,
               32'h78442211, 10, 3, 6, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        iv    = '0;
        md_a  = '0;
        or_a  = '0;
        for (int k = 0; k < 3; k++) begin
            rnd_a[k] = 8'h00;
            ish[k]   = 32'h0;
        end
        test_reset();
        test_refresh_n2_hold();
        test_unmask_n2();
        test_refresh_n3_gap0();
        test_unmask_n4_gap2();
        test_reset_in_prech();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/isolated_share_remasker.md
ISOLATED_SHARE_REMASKER -- requirements
Module: isolated_share_remasker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of one share.
REQ-002 SHALL have parameter NSHARES, default 2, number of shares; legal range 2..4.
REQ-003 SHALL have parameter GAP, default 1, precharge cycles between consecutive share steps; legal range 0..3.
REQ-004 SHALL have port clk  input  1  clock, all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  input shares valid.
REQ-007 SHALL have port in_ready  output  1  block accepts input.
REQ-008 SHALL have port in_shares  input  NSHARES*WIDTH  share i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port mode  input  1  0 = REFRESH, 1 = UNMASK; sampled only at accept.
REQ-010 SHALL have port rnd  input  WIDTH  fresh randomness, sampled when rnd_req is high.
REQ-011 SHALL have port rnd_req  output  1  rnd consumed at this edge.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port out_shares  output  NSHARES*WIDTH  result, same lane packing as in_shares.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, PROC, PRECH, DONE.
REQ-017 SHALL assert in_ready only in IDLE; accept occurs on the edge where in_valid and in_ready are both high; the FSM then enters PROC with index 0.
REQ-018 SHALL process exactly one share per PROC cycle through a single WIDTH-bit datapath register; no two share values SHALL be combined in the same cycle, except in the UNMASK accumulator.
REQ-019 SHALL, in REFRESH, compute share_i ^ r_i for i < NSHARES-1, and share_last ^ (XOR of all r_i), using a secret-independent mask accumulator.
REQ-020 SHALL, in UNMASK, place XOR of all shares in lane 0 and zero in all other lanes.
REQ-021 SHALL assert rnd_req only in PROC, in REFRESH mode, when index < NSHARES-1.
REQ-022 SHALL, after each PROC edge with index < NSHARES-1, enter PRECH for GAP cycles and then return to PROC with index+1; if GAP = 0, it SHALL go directly to PROC with index+1.
REQ-023 SHALL drive the datapath register to zero during every PRECH cycle.
REQ-024 SHALL enter DONE after the PROC edge for index NSHARES-1; out_valid SHALL be high exactly NSHARES + (NSHARES-1)*GAP edges after the accept edge.
REQ-025 SHALL hold out_valid high and out_shares stable in DONE until out_ready is high; on that edge it SHALL return to IDLE and zeroize share storage, the accumulators and out_shares.
REQ-026 SHALL ignore in_valid, mode and rnd changes outside their sampling points.
REQ-027 SHALL drive out_shares to zero whenever out_valid is low.

Reset
REQ-028 SHALL, on rst_n low at any state including mid-PROC or PRECH, abort the operation immediately.
REQ-029 SHALL, on reset, clear all share storage, the datapath register, both accumulators and the counters.
REQ-030 SHALL, on reset, set state to IDLE with in_ready = 1 and out_valid, rnd_req, busy = 0.

Structure
REQ-031 SHALL place the state enum, the MODE_REFRESH/MODE_UNMASK constants and the NSHARES/GAP legal-range checks in package isolated_share_pkg.
REQ-032 SHALL implement the precharge and index counters as sub-module share_step_sequencer, which drives FSM step and index control.

Verification
REQ-033 SHALL cover: NSHARES=2, GAP=1, REFRESH, shares 0xA5/0x3C, rnd 0x0F -> out 0xAA/0x33, out_valid 3 edges after accept.
REQ-034 SHALL cover: NSHARES=2, UNMASK, shares 0xA5/0x3C -> lane0 0x99, lane1 0x00, rnd_req never high.
REQ-035 SHALL cover: NSHARES=3, GAP=0, REFRESH, shares 0x11/0x22/0x44, rnd 0x01 then 0x02 -> 0x10/0x20/0x47, latency 3.
REQ-036 SHALL cover: NSHARES=4, GAP=2 -> latency 10 edges, datapath register 0 in all 6 PRECH cycles.
REQ-037 SHALL cover: out_ready held low for 5 cycles in DONE -> out_shares stable and in_ready 0; on release the block returns to IDLE and out_shares becomes 0.
REQ-038 SHALL cover: rst_n pulsed during PRECH -> all outputs 0 and in_ready 1 after release, and a subsequent accept produces a correct result.
